// File: rtl/updown_count_monitor.sv
// Purpose: watches samples from an up/down counter, infers direction, flags wraps and illegal steps.
// Latency: every output is registered and reflects a valid sample in the cycle after it is taken.
// Backpressure: none; a sample is accepted whenever valid is high, and idle cycles hold the state.
module updown_count_monitor #(
    parameter int size = 4                  // legal range 2..16
) (
    input  logic            clk,
    input  logic            reset,          // synchronous, active low
    input  logic            valid,
    input  logic [size-1:0] count,
    output logic            dir_valid,
    output logic            dir,            // 1 = up, 0 = down
    output logic            lock,
    output logic            wrap,
    output logic            step_err,
    output logic [7:0]      err_count
);

    // EMPTY: no history; FIRST: one sample held, no direction; UP/DOWN: direction known
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] FIRST = 2'd1;
    localparam logic [1:0] UP    = 2'd2;
    localparam logic [1:0] DOWN  = 2'd3;

    localparam logic [size-1:0] CNT_MAX = {size{1'b1}};
    localparam logic [size-1:0] CNT_ONE = {{(size-1){1'b0}}, 1'b1};
    localparam logic [1:0]      RUN_MAX = 2'd3;

    logic [1:0]      state,     state_nxt;
    logic [size-1:0] prev,      prev_nxt;
    logic [1:0]      run,       run_nxt;
    logic            dir_valid_nxt;
    logic            dir_nxt;
    logic            lock_nxt;
    logic            wrap_nxt;
    logic            step_err_nxt;
    logic [7:0]      err_count_nxt;

    logic [size-1:0] delta;
    logic            step_up;
    logic            step_dn;

    // Step classification: modular difference must be exactly +1 or -1
    always_comb begin
        delta   = count - prev;
        step_up = (delta == CNT_ONE);
        step_dn = (delta == CNT_MAX);
    end

    // Next-state: hold everything by default, pulses default low
    always_comb begin
        state_nxt     = state;
        prev_nxt      = prev;
        run_nxt       = run;
        dir_valid_nxt = dir_valid;
        dir_nxt       = dir;
        wrap_nxt      = 1'b0;
        step_err_nxt  = 1'b0;
        err_count_nxt = err_count;

        if (valid) begin
            // Any accepted sample becomes the new reference, legal or not
            prev_nxt = count;
            if (state == EMPTY) begin
                state_nxt = FIRST;
            end else if (step_up) begin
                state_nxt     = UP;
                dir_nxt       = 1'b1;
                dir_valid_nxt = 1'b1;
                if (state == UP) begin
                    run_nxt = (run == RUN_MAX) ? RUN_MAX : run + 2'd1;
                end else begin
                    run_nxt = 2'd1;
                end
                wrap_nxt = (prev == CNT_MAX);
            end else if (step_dn) begin
                state_nxt     = DOWN;
                dir_nxt       = 1'b0;
                dir_valid_nxt = 1'b1;
                if (state == DOWN) begin
                    run_nxt = (run == RUN_MAX) ? RUN_MAX : run + 2'd1;
                end else begin
                    run_nxt = 2'd1;
                end
                wrap_nxt = (prev == {size{1'b0}});
            end else begin
                // Stall or jump: drop direction confidence but keep the sample as new reference
                state_nxt     = FIRST;
                run_nxt       = 2'd0;
                dir_valid_nxt = 1'b0;
                step_err_nxt  = 1'b1;
                err_count_nxt = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;
            end
        end

        lock_nxt = (run_nxt == RUN_MAX);
    end

    // State and output registers with synchronous active-low reset taking priority over valid
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= EMPTY;
            prev      <= {size{1'b0}};
            run       <= 2'd0;
            dir_valid <= 1'b0;
            dir       <= 1'b0;
            lock      <= 1'b0;
            wrap      <= 1'b0;
            step_err  <= 1'b0;
            err_count <= 8'd0;
        end else begin
            state     <= state_nxt;
            prev      <= prev_nxt;
            run       <= run_nxt;
            dir_valid <= dir_valid_nxt;
            dir       <= dir_nxt;
            lock      <= lock_nxt;
            wrap      <= wrap_nxt;
            step_err  <= step_err_nxt;
            err_count <= err_count_nxt;
        end
    end

endmodule

// File: tb/tb_updown_count_monitor.sv
// Purpose: randomized and directed checking of updown_count_monitor against a sample-history model.
// Latency: each driven cycle is checked 1 time unit after the rising edge that takes it.
// Backpressure: not applicable; the bench drives one sample (or gap) per clock.
module tb_updown_count_monitor;

    localparam int SIZE = 4;
    localparam int M    = 1 << SIZE;

    logic            clk;
    logic            reset;
    logic            valid;
    logic [SIZE-1:0] count;
    logic            dir_valid;
    logic            dir;
    logic            lock;
    logic            wrap;
    logic            step_err;
    logic [7:0]      err_count;

    int n_checks;
    int n_fail;

    // Reference model: history of samples expressed as plain integers
    bit m_has_prev;
    int m_prev;
    bit m_have_dir;
    int m_dir;
    int m_run;
    int m_dv;
    int m_lock;
    int m_wrap;
    int m_err;
    int m_ecnt;

    updown_count_monitor #(.size(SIZE)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .count     (count),
        .dir_valid (dir_valid),
        .dir       (dir),
        .lock      (lock),
        .wrap      (wrap),
        .step_err  (step_err),
        .err_count (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input int r, input int v, input int c);
        int d;
        if (r == 0) begin
            m_has_prev = 0; m_prev = 0; m_have_dir = 0; m_dir = 0; m_run = 0;
            m_dv = 0; m_lock = 0; m_wrap = 0; m_err = 0; m_ecnt = 0;
        end else begin
            m_wrap = 0;
            m_err  = 0;
            if (v != 0) begin
                if (!m_has_prev) begin
                    m_has_prev = 1;
                end else begin
                    d = (c - m_prev + M) % M;
                    if (d == 1 || d == M - 1) begin
                        int up;
                        up = (d == 1) ? 1 : 0;
                        m_wrap = (up == 1) ? int'(m_prev == M - 1) : int'(m_prev == 0);
                        if (m_have_dir && m_dir == up) m_run = (m_run + 1 > 3) ? 3 : m_run + 1;
                        else m_run = 1;
                        m_have_dir = 1;
                        m_dir = up;
                        m_dv = 1;
                    end else begin
                        m_err = 1;
                        m_ecnt = (m_ecnt + 1 > 255) ? 255 : m_ecnt + 1;
                        m_run = 0;
                        m_dv = 0;
                        m_have_dir = 0;
                    end
                    m_lock = (m_run == 3) ? 1 : 0;
                end
                m_prev = c;
            end
        end
    endtask

    // Drive one cycle, let the edge take it, then compare every output to the model
    task automatic step(input int r, input int v, input int c);
        reset = (r != 0);
        valid = (v != 0);
        count = SIZE'(c % M);
        @(posedge clk);
        model_update(r, v, c % M);
        #1;
        check("dir_valid", int'(dir_valid), m_dv);
        check("dir",       int'(dir),       m_dir);
        check("lock",      int'(lock),      m_lock);
        check("wrap",      int'(wrap),      m_wrap);
        check("step_err",  int'(step_err),  m_err);
        check("err_count", int'(err_count), m_ecnt);
    endtask

    initial begin
        int last;
        int r;
        int v;
        int c;
        int sel;
        n_checks = 0;
        n_fail   = 0;
        m_has_prev = 0; m_prev = 0; m_have_dir = 0; m_dir = 0; m_run = 0;
        m_dv = 0; m_lock = 0; m_wrap = 0; m_err = 0; m_ecnt = 0;
        reset = 1'b0;
        valid = 1'b0;
        count = '0;

        // Reset state
        step(0, 0, 0);
        check("rst_dir_valid", int'(dir_valid), 0);
        check("rst_err_count", int'(err_count), 0);

        // Counting up 0,1,2,3 acquires direction then lock
        step(1, 1, 0);
        step(1, 1, 1);
        check("up_dir_valid", int'(dir_valid), 1);
        check("up_dir", int'(dir), 1);
        step(1, 1, 2);
        check("up_nolock_run2", int'(lock), 0);
        step(1, 1, 3);
        check("up_lock", int'(lock), 1);
        check("up_no_errs", int'(err_count), 0);

        // Up-wrap at 15->0, then reverse through the boundary
        for (int i = 4; i < 16; i++) step(1, 1, i);
        step(1, 1, 0);
        check("upwrap_pulse", int'(wrap), 1);
        check("upwrap_lock", int'(lock), 1);
        check("upwrap_dir", int'(dir), 1);
        step(1, 1, 15);
        check("dnwrap_pulse", int'(wrap), 1);
        check("dnwrap_dir", int'(dir), 0);
        check("dnwrap_lock", int'(lock), 0);
        step(1, 1, 14);
        check("rev_dir", int'(dir), 0);
        check("rev_lock", int'(lock), 0);
        check("rev_wrap", int'(wrap), 0);
        step(1, 1, 13);
        check("rev_lock_run3", int'(lock), 1);

        // Jump is illegal, then recovery
        step(0, 0, 0);
        step(1, 1, 5);
        step(1, 1, 6);
        step(1, 1, 9);
        check("jump_err", int'(step_err), 1);
        check("jump_errcnt", int'(err_count), 1);
        check("jump_dir_valid", int'(dir_valid), 0);
        step(1, 1, 10);
        check("recover_dir_valid", int'(dir_valid), 1);
        check("recover_dir", int'(dir), 1);
        check("recover_no_err", int'(step_err), 0);

        // Stall is illegal
        step(1, 1, 7);
        step(1, 1, 7);
        check("stall_err", int'(step_err), 1);

        // Gaps are not errors and keep the run
        step(0, 0, 0);
        step(1, 1, 4);
        step(1, 1, 3);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        check("gap_hold_dir_valid", int'(dir_valid), 1);
        step(1, 1, 2);
        check("gap_dir", int'(dir), 0);
        check("gap_no_err", int'(step_err), 0);
        check("gap_nolock", int'(lock), 0);
        step(1, 1, 1);
        check("gap_run_kept", int'(lock), 1);

        // Error counter saturation, then reset overriding a sample
        step(0, 0, 0);
        for (int i = 0; i < 301; i++) step(1, 1, 7);
        check("errcnt_sat", int'(err_count), 255);
        step(0, 1, 8);
        check("rst_mid_errcnt", int'(err_count), 0);
        check("rst_mid_err", int'(step_err), 0);
        check("rst_mid_dir_valid", int'(dir_valid), 0);
        check("rst_mid_lock", int'(lock), 0);
        step(1, 1, 9);
        check("post_rst_empty", int'(dir_valid), 0);
        check("post_rst_no_err", int'(step_err), 0);
        step(1, 1, 10);
        check("post_rst_dir_valid", int'(dir_valid), 1);

        // Randomized traffic biased toward legal steps
        last = 10;
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 199) != 0) ? 1 : 0;
            v   = ($urandom_range(0, 3) != 0) ? 1 : 0;
            sel = int'($urandom_range(0, 9));
            if (sel < 5)      c = (last + 1) % M;
            else if (sel < 8) c = (last + M - 1) % M;
            else if (sel == 8) c = last;
            else              c = int'($urandom_range(0, M - 1));
            step(r, v, c);
            if (v != 0) last = c;
            check("no_wrap_and_err", int'(wrap & step_err), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_count_monitor.md
UPDOWN_COUNT_MONITOR -- requirements
Module: updown_count_monitor

Interface
REQ-001 The block SHALL have parameter `size`, default 4: width of the observed count; legal range 2..16.
REQ-002 The block SHALL have input `clk`, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have input `reset`, 1 bit: synchronous, active-low reset, sampled on the rising edge of `clk`.
REQ-004 The block SHALL have input `valid`, 1 bit: `count` carries a sample this cycle.
REQ-005 The block SHALL have input `count`, `size` bits: unsigned value from an up/down counter.
REQ-006 The block SHALL have output `dir_valid`, 1 bit: `dir` is meaningful.
REQ-007 The block SHALL have output `dir`, 1 bit: inferred direction; 1 = up, 0 = down.
REQ-008 The block SHALL have output `lock`, 1 bit: at least 3 consecutive legal steps in the current direction.
REQ-009 The block SHALL have output `wrap`, 1 bit: one-cycle pulse when a legal step crossed the modulus boundary.
REQ-010 The block SHALL have output `step_err`, 1 bit: one-cycle pulse when a sample was an illegal step.
REQ-011 The block SHALL have output `err_count`, 8 bits: saturating total of `step_err` pulses.

Function
REQ-012 All outputs SHALL be registered; each output SHALL reflect a `valid` sample in the cycle after that sample is taken.
REQ-013 The state machine SHALL have states EMPTY (no previous sample), FIRST (previous sample held, no direction yet), UP and DOWN.
REQ-014 On each `valid` sample in FIRST, UP or DOWN, delta SHALL be computed as (count - prev) mod 2^size.
REQ-015 delta = 1 SHALL be a legal up step; delta = 2^size-1 SHALL be a legal down step; any other delta, including 0, SHALL be illegal.
REQ-016 A `valid` sample in EMPTY SHALL store prev and move to FIRST, with no pulse output.
REQ-017 A legal step SHALL move the FSM to UP or DOWN, set `dir` to match and set `dir_valid` = 1.
REQ-018 A legal step in the same direction as the current state SHALL increment the run counter, which saturates at 3.
REQ-019 A legal step from FIRST, or in the opposite direction to the current state, SHALL set the run to 1 and clear `lock`; a direction change SHALL NOT be an error.
REQ-020 `lock` SHALL be 1 exactly when run = 3.
REQ-021 An illegal step SHALL pulse `step_err`, increment `err_count` (holding at 255), clear the run, `lock` and `dir_valid`, and move the FSM to FIRST.
REQ-022 Every sample taken in FIRST, UP or DOWN, legal or not, SHALL update prev to `count`.
REQ-023 `wrap` SHALL pulse on a legal up step from 2^size-1 to 0 and on a legal down step from 0 to 2^size-1.
REQ-024 With `valid` = 0, state, `dir`, `dir_valid` and `lock` SHALL hold, and `wrap` and `step_err` SHALL be 0; gaps SHALL NOT be errors.
REQ-025 Only one sample SHALL be taken per cycle, and `wrap` and `step_err` SHALL never be asserted together.

Reset
REQ-026 When `reset` = 0 at a rising edge, the block SHALL return to EMPTY with prev = 0, run = 0, `dir_valid` = 0, `dir` = 0, `lock` = 0, `wrap` = 0, `step_err` = 0 and `err_count` = 0.
REQ-027 Reset SHALL take priority over `valid`, and a sample taken in a cycle with `reset` = 0 SHALL be discarded.
REQ-028 Reset asserted mid-stream SHALL discard history, so the first sample after release is treated as taken in EMPTY.

Verification
REQ-029 The bench SHALL cover: reset, then `valid` samples 0,1,2,3 -> `dir_valid` = 1 and `dir` = 1 after the sample of 1; `lock` = 1 after the sample of 3; `err_count` = 0.
REQ-030 The bench SHALL cover: up-locked at 15, then sample 0 -> `wrap` pulse, `lock` stays 1, `dir` = 1; then samples 15,14 -> `wrap` pulse on the sample of 15, and `dir` = 0 with `lock` = 0 and run = 2 after the sample of 14.
REQ-031 The bench SHALL cover: samples 5,6 then 9 -> `step_err` pulse, `err_count` = 1, `dir_valid` = 0; then sample 10 -> `dir_valid` = 1, `dir` = 1.
REQ-032 The bench SHALL cover: samples 7,7 -> `step_err` pulse on the second sample of 7 (stall is illegal).
REQ-033 The bench SHALL cover: samples 4,3 with `valid` = 0 for 5 cycles, then sample 2 -> `dir` = 0, run = 2, no `step_err`.
REQ-034 The bench SHALL cover: 300 illegal samples -> `err_count` = 255; then `reset` = 0 for one edge at the same time as `valid` = 1 -> all outputs return to their reset values and the sample is ignored.
